// File: rtl/ula_pkg.sv
// Shared definitions for the ALU controller: opcode map, FSM encoding and
// opcode classification helpers used by the controller and the ALU.
package ula_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] OP_SOMA  = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MULT  = 4'h2;
    localparam logic [3:0] OP_QUOC  = 4'h3;
    localparam logic [3:0] OP_RESTO = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_NAND  = 4'h8;
    localparam logic [3:0] OP_NOR   = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ops that take the multi-cycle path
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_QUOC) || (op == OP_RESTO);
    endfunction

    // Holes in the opcode map
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'h5) || (op >= 4'hC);
    endfunction

endpackage

// File: rtl/ula_8bits.sv
// 8-bit ALU, purely combinational.
// Ports: A, B operands; Sel_Op opcode; Resultado 16-bit result;
//        Maior/Menor/Igual unsigned comparison of A vs B.
module ula_8bits
    import ula_pkg::*;
(
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [3:0]  Sel_Op,
    output logic [15:0] Resultado,
    output logic        Maior,
    output logic        Menor,
    output logic        Igual
);

    always_comb begin
        Resultado = '0;
        case (Sel_Op)
            OP_SOMA:  Resultado = 16'(A) + 16'(B);
            OP_SUB:   Resultado = 16'(A) - 16'(B);
            OP_MULT:  Resultado = 16'(A) * 16'(B);
            OP_QUOC:  if (B != 8'd0) Resultado = 16'(A / B);
            OP_RESTO: if (B != 8'd0) Resultado = 16'(A % B);
            OP_AND:   Resultado = 16'(A & B);
            OP_OR:    Resultado = 16'(A | B);
            OP_NAND:  Resultado = 16'(~(A & B));
            OP_NOR:   Resultado = 16'(~(A | B));
            OP_XOR:   Resultado = 16'(A ^ B);
            OP_NOT:   Resultado = 16'(~A);
            default:  Resultado = '0;
        endcase
    end

    assign Maior = (A > B);
    assign Menor = (A < B);
    assign Igual = (A == B);

endmodule

// File: rtl/ula_rr_arb2.sv
// Two-way round-robin arbiter. Priority flips to the other requester on
// every accept, so contention alternates grants.
// Ports: valid[1:0] requests; enable arbitration window; grant[1:0] one-hot
//        (combinational); grant_id index of the winner.
module ula_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic prio_q;
    logic accept;

    // Sole requester wins; on contention the prioritised one wins
    always_comb begin
        grant_id = (valid == 2'b11) ? prio_q : valid[1];
        accept   = enable && (valid != 2'b00);
        grant    = 2'b00;
        if (accept) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~grant_id;
        end
    end

endmodule

// File: rtl/ula_ctrl_arb.sv
// Shares one ula_8bits between two valid/ready requesters. Accepts one op
// at a time, holds operands for the op's execution time, then presents the
// registered result on the response channel until it is taken.
// Ports: clk, rst_n; Req0_*/Req1_* request channels (Valid, Ready, A, B, Op);
//        Resp_Valid/Resp_Ready handshake; Resp_Id, Resp_Resultado,
//        Resp_Maior/Menor/Igual, Resp_Erro response payload.
module ula_ctrl_arb
    import ula_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 3,
    parameter int unsigned ALU_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req0_Valid,
    output logic        Req0_Ready,
    input  logic [7:0]  Req0_A,
    input  logic [7:0]  Req0_B,
    input  logic [3:0]  Req0_Op,
    input  logic        Req1_Valid,
    output logic        Req1_Ready,
    input  logic [7:0]  Req1_A,
    input  logic [7:0]  Req1_B,
    input  logic [3:0]  Req1_Op,
    output logic        Resp_Valid,
    input  logic        Resp_Ready,
    output logic        Resp_Id,
    output logic [15:0] Resp_Resultado,
    output logic        Resp_Maior,
    output logic        Resp_Menor,
    output logic        Resp_Igual,
    output logic        Resp_Erro
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic               id_q, id_d;
    logic               rvalid_q, rvalid_d;
    logic               rid_q, rid_d;
    logic [15:0]        rres_q, rres_d;
    logic               rmaior_q, rmaior_d, rmenor_q, rmenor_d, rigual_q, rigual_d;
    logic               rerro_q, rerro_d;

    logic [1:0]         grant;
    logic               grant_id;
    logic               arb_en;
    logic               accept;
    logic [7:0]         sel_a, sel_b;
    logic [3:0]         sel_op;
    logic               reject;
    logic [15:0]        alu_res;
    logic               alu_maior, alu_menor, alu_igual;

    // Arbitration only in IDLE; reset also forces the Ready outputs low
    assign arb_en = (state_q == ST_IDLE) && rst_n;
    assign accept = arb_en && (Req0_Valid || Req1_Valid);

    ula_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    ({Req1_Valid, Req0_Valid}),
        .enable   (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign Req0_Ready = grant[0];
    assign Req1_Ready = grant[1];

    assign sel_a  = grant_id ? Req1_A  : Req0_A;
    assign sel_b  = grant_id ? Req1_B  : Req0_B;
    assign sel_op = grant_id ? Req1_Op : Req0_Op;
    assign reject = is_illegal(sel_op) ||
                    (((sel_op == OP_QUOC) || (sel_op == OP_RESTO)) && (sel_b == 8'd0));

    // ALU sees only the captured operands, so its inputs are frozen in EXEC
    ula_8bits u_alu (
        .A         (a_q),
        .B         (b_q),
        .Sel_Op    (op_q),
        .Resultado (alu_res),
        .Maior     (alu_maior),
        .Menor     (alu_menor),
        .Igual     (alu_igual)
    );

    // Next-state and response-register logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rres_d   = rres_q;
        rmaior_d = rmaior_q;
        rmenor_d = rmenor_q;
        rigual_d = rigual_q;
        rerro_d  = rerro_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d  = sel_a;
                    b_d  = sel_b;
                    op_d = sel_op;
                    id_d = grant_id;
                    if (reject) begin
                        // Rejected ops skip the ALU entirely
                        state_d  = ST_RESP;
                        rvalid_d = 1'b1;
                        rid_d    = grant_id;
                        rres_d   = '0;
                        rerro_d  = 1'b1;
                        rmaior_d = (sel_a > sel_b);
                        rmenor_d = (sel_a < sel_b);
                        rigual_d = (sel_a == sel_b);
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = is_muldiv(sel_op) ? CNT_W'(MULDIV_CYCLES - 1)
                                                    : CNT_W'(ALU_CYCLES - 1);
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    rvalid_d = 1'b1;
                    rid_d    = id_q;
                    // Only the product uses the upper result byte
                    rres_d   = (op_q == OP_MULT) ? alu_res : {8'h00, alu_res[7:0]};
                    rerro_d  = 1'b0;
                    rmaior_d = alu_maior;
                    rmenor_d = alu_menor;
                    rigual_d = alu_igual;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (Resp_Ready) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
            rres_q   <= '0;
            rmaior_q <= 1'b0;
            rmenor_q <= 1'b0;
            rigual_q <= 1'b0;
            rerro_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rres_q   <= rres_d;
            rmaior_q <= rmaior_d;
            rmenor_q <= rmenor_d;
            rigual_q <= rigual_d;
            rerro_q  <= rerro_d;
        end
    end

    assign Resp_Valid     = rvalid_q;
    assign Resp_Id        = rid_q;
    assign Resp_Resultado = rres_q;
    assign Resp_Maior     = rmaior_q;
    assign Resp_Menor     = rmenor_q;
    assign Resp_Igual     = rigual_q;
    assign Resp_Erro      = rerro_q;

endmodule

// File: tb/tb_ula_ctrl_arb.sv
// Bench for ula_ctrl_arb: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction model.
module tb_ula_ctrl_arb;

    localparam int unsigned MULDIV_CYCLES = 3;
    localparam int unsigned ALU_CYCLES    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
    logic [7:0]  Req0_A, Req0_B, Req1_A, Req1_B;
    logic [3:0]  Req0_Op, Req1_Op;
    logic        Resp_Valid, Resp_Ready, Resp_Id;
    logic [15:0] Resp_Resultado;
    logic        Resp_Maior, Resp_Menor, Resp_Igual, Resp_Erro;

    int checks = 0;
    int failures = 0;

    ula_ctrl_arb #(.MULDIV_CYCLES(MULDIV_CYCLES), .ALU_CYCLES(ALU_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A),
        .Req0_B(Req0_B), .Req0_Op(Req0_Op),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A),
        .Req1_B(Req1_B), .Req1_Op(Req1_Op),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Id(Resp_Id),
        .Resp_Resultado(Resp_Resultado), .Resp_Maior(Resp_Maior),
        .Resp_Menor(Resp_Menor), .Resp_Igual(Resp_Igual), .Resp_Erro(Resp_Erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_res(input int a, input int b, input int op);
        case (op)
            0:  return 16'((a + b) % 256);
            1:  return 16'((a - b + 256) % 256);
            2:  return 16'(a * b);
            3:  return 16'(a / b);
            4:  return 16'(a % b);
            6:  return 16'(a & b);
            7:  return 16'(a | b);
            8:  return 16'(255 - (a & b));
            9:  return 16'(255 - (a | b));
            10: return 16'(a ^ b);
            11: return 16'(255 - a);
            default: return 16'(0);
        endcase
    endfunction

    function automatic bit ref_err(input int b, input int op);
        return (op == 5) || (op >= 12) || (((op == 3) || (op == 4)) && (b == 0));
    endfunction

    function automatic int ref_cycles(input int op);
        return (op == 2 || op == 3 || op == 4) ? int'(MULDIV_CYCLES) : int'(ALU_CYCLES);
    endfunction

    // Model: at most one op in flight, response appears at a known cycle
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_rdy_cyc = 0;
    bit          m_prio = 0;
    int          m_w;
    bit          m_exp_valid;
    int          m_a, m_b, m_op;
    bit          m_err;
    logic [20:0] m_resp;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs",
                {Req0_Ready, Req1_Ready, Resp_Valid, Resp_Id, Resp_Maior, Resp_Menor,
                 Resp_Igual, Resp_Erro, Resp_Resultado}, 0);
            m_busy = 0;
            m_prio = 0;
        end else begin
            m_exp_valid = m_busy && (cyc >= m_rdy_cyc);
            m_w = -1;
            if (!m_busy) begin
                if (Req0_Valid && Req1_Valid) m_w = int'(m_prio);
                else if (Req0_Valid)          m_w = 0;
                else if (Req1_Valid)          m_w = 1;
            end
            chk("req_ready", {Req1_Ready, Req0_Ready}, {30'd0, m_w == 1, m_w == 0});
            chk("resp_valid", Resp_Valid, m_exp_valid);
            if (m_exp_valid && Resp_Valid) begin
                chk("resp_payload",
                    {Resp_Id, Resp_Erro, Resp_Maior, Resp_Menor, Resp_Igual, Resp_Resultado},
                    m_resp);
            end
            if (m_exp_valid && Resp_Ready) begin
                m_busy = 0;
            end else if (m_w >= 0) begin
                m_a  = (m_w == 0) ? int'(Req0_A)  : int'(Req1_A);
                m_b  = (m_w == 0) ? int'(Req0_B)  : int'(Req1_B);
                m_op = (m_w == 0) ? int'(Req0_Op) : int'(Req1_Op);
                m_err = ref_err(m_b, m_op);
                m_resp = {m_w == 1, m_err, m_a > m_b, m_a < m_b, m_a == m_b,
                          m_err ? 16'd0 : ref_res(m_a, m_b, m_op)};
                m_busy = 1;
                m_rdy_cyc = cyc + 1 + (m_err ? 0 : ref_cycles(m_op));
                m_prio = (m_w == 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input int a, input int b, input int op);
        if (r == 0) begin
            Req0_Valid = v; Req0_A = 8'(a); Req0_B = 8'(b); Req0_Op = 4'(op);
        end else begin
            Req1_Valid = v; Req1_A = 8'(a); Req1_B = 8'(b); Req1_Op = 4'(op);
        end
    endtask

    // Issue one op, check literal latency and payload, return at posedge+1
    task automatic do_op(input string nm, input int r, input int a, input int b, input int op,
                         input int eres, input bit eerr, input int elat, input logic [2:0] eflg);
        int n;
        bit got;
        set_req(r, 1, a, b, op);
        got = 0; n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = (r == 0) ? Req0_Ready : Req1_Ready;
        end
        chk({nm, "_accept"}, got, 1);
        if (!got) begin
            set_req(r, 0, 0, 0, 0);
            return;
        end
        tick();
        set_req(r, 0, 0, 0, 0);
        got = 0; n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = Resp_Valid;
        end
        chk({nm, "_latency"}, n, elat);
        if (got) begin
            chk({nm, "_result"}, Resp_Resultado, eres);
            chk({nm, "_erro"}, Resp_Erro, eerr);
            chk({nm, "_flags"}, {Resp_Maior, Resp_Menor, Resp_Igual}, eflg);
            chk({nm, "_id"}, Resp_Id, r);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        rst_n = 1'b0;
        Resp_Ready = 1'b1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic add, multiply and comparison flags
        do_op("add", 0, 50, 30, 0, 80, 0, 2, 3'b100);
        do_op("mul_sq", 1, 20, 20, 2, 400, 0, 4, 3'b001);
        do_op("mul", 1, 3, 90, 2, 270, 0, 4, 3'b010);

        // Rejections, then a legal remainder
        do_op("rem_div0", 0, 23, 0, 4, 0, 1, 1, 3'b100);
        do_op("illegal", 0, 7, 3, 5, 0, 1, 1, 3'b100);
        do_op("rem", 0, 23, 5, 4, 3, 0, 4, 3'b100);

        // Back-pressure: response held, no grants while pending
        Resp_Ready = 1'b0;
        do_op("bp_add", 1, 200, 100, 0, 44, 0, 2, 3'b100);
        set_req(0, 1, 9, 4, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_ready", {Req1_Ready, Req0_Ready}, 0);
            chk("bp_hold", {Resp_Valid, Resp_Resultado}, {1'b1, 16'd44});
            tick();
        end
        Resp_Ready = 1'b1;
        @(negedge clk);
        chk("bp_release_noaccept", {Resp_Valid, Req0_Ready}, 2'b10);
        tick();
        do_op("after_bp", 0, 9, 4, 1, 5, 0, 2, 3'b100);

        // Async reset during a multi-cycle divide
        set_req(0, 1, 100, 5, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (!Req0_Ready && n < 50);
        tick();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset",
               {Req0_Ready, Req1_Ready, Resp_Valid, Resp_Id, Resp_Maior, Resp_Menor,
                Resp_Igual, Resp_Erro, Resp_Resultado}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_resp_after_reset", Resp_Valid, 0);
        end
        tick();
        do_op("div", 0, 100, 5, 3, 20, 0, 4, 3'b100);

        // Contention after a fresh reset: grants alternate starting at 0
        @(negedge clk);
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        set_req(0, 1, $urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 11));
        set_req(1, 1, $urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 11));
        k = 0; n = 0;
        while (k < 8 && n < 300) begin
            @(negedge clk);
            n++;
            if (Req0_Ready || Req1_Ready) begin
                chk("rr_order", Req1_Ready, k % 2);
                chk("rr_onehot", Req0_Ready & Req1_Ready, 0);
                k++;
            end
            tick();
            set_req(0, 1, $urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 11));
            set_req(1, 1, $urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 11));
        end
        chk("rr_grants", k, 8);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (10) tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_req(0, ($urandom % 3) != 0, $urandom % 256,
                    (($urandom % 4) == 0) ? 0 : $urandom % 256, $urandom % 16);
            set_req(1, ($urandom % 3) != 0, $urandom % 256,
                    (($urandom % 4) == 0) ? 0 : $urandom % 256, $urandom % 16);
            Resp_Ready = ($urandom % 4) != 0;
            tick();
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        Resp_Ready = 1'b1;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ula_ctrl_arb.md
Name: ula_ctrl_arb

Overview:
- Controller that shares one ula_8bits instance between two requesters.
- Per requester: valid/ready request channel carrying A, B, Sel_Op.
- Grants round-robin, holds operands stable for the op-dependent execution time, and returns the registered result, flags and requester ID on a valid/ready response channel.
- Rejects division by zero and unused opcodes with an error response, without executing them.

Parameters:
- MULDIV_CYCLES, 3: execution cycles for Sel_Op 0010/0011/0100 (multi-cycle path); legal range 1..15.
- ALU_CYCLES, 1: execution cycles for all other legal opcodes; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- Req0_Valid  in  1  requester 0 has an operation.
- Req0_Ready  out  1  requester 0 accepted this cycle.
- Req0_A  in  8  operand A.
- Req0_B  in  8  operand B.
- Req0_Op  in  4  opcode.
- Req1_Valid, Req1_Ready, Req1_A, Req1_B, Req1_Op: same as requester 0.
- Resp_Valid  out  1  response available.
- Resp_Ready  in  1  consumer takes the response.
- Resp_Id  out  1  requester that issued the op.
- Resp_Resultado  out  16  result.
- Resp_Maior, Resp_Menor, Resp_Igual  out  1 each  comparison flags of A vs B (unsigned).
- Resp_Erro  out  1  op rejected.

Behaviour:
- Opcodes (unchanged ula_8bits map):
  - 0000 soma, 0001 sub, 0010 mult, 0011 quociente, 0100 resto.
  - 0110 AND, 0111 OR, 1000 NAND, 1001 NOR, 1010 XOR, 1011 NOT.
  - 0101 and 1100-1111 are illegal.
- Reset (async, rst_n=0):
  - state=IDLE, Prio=0, counter=0.
  - All outputs 0: Req*_Ready, Resp_Valid, Resp_Id, Resp_Resultado, flags, Resp_Erro.
  - Effect is immediate, including mid-EXEC or mid-RESP; the in-flight op is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Req*_Ready is combinational and high only for the winner.
  - Winner: the sole valid requester; if both valid, the requester equal to Prio.
  - Accept edge = Valid&Ready sampled high. On that edge:
    - Capture A, B, Op and Id into operand registers.
    - Prio <= ~Id.
- Error check at accept (Op illegal, or Op 0011/0100 with B=0):
  - Go directly to RESP with Resp_Erro=1, Resp_Resultado=0.
  - Flags reflect captured A vs B.
- Legal op at accept: go to EXEC with counter = cycles-1 (MULDIV_CYCLES or ALU_CYCLES).
- EXEC:
  - Registered operands drive the ula_8bits inputs; they are constant for the whole state.
  - Req*_Ready=0.
  - Counter decrements each cycle.
  - On the edge where counter==0, register the result and flags, then go to RESP.
- Result width rule: Resp_Resultado[15:8] forced to 0 for every op except 0010; 0010 passes the full 16-bit product.
- Latency (accept edge to first cycle with Resp_Valid=1): cycles+1 clocks; error ops: 1 clock.
- RESP:
  - Resp_Valid=1; all Resp_* held stable while Resp_Ready=0, with no timeout.
  - Req*_Ready=0.
  - On Resp_Valid&Resp_Ready: go to IDLE, Resp_Valid=0 next cycle.
  - A new accept is possible at the earliest the cycle after return to IDLE, so minimum issue interval = latency+1.
- Resp_* data outputs keep their last value in IDLE/EXEC and are only meaningful while Resp_Valid=1.
- A requester dropping Valid while not granted is legal; there is no request queueing.
- A single requester valid every cycle is always served; round-robin guarantees starvation-freedom under contention.

Decomposition:
- Package ula_pkg:
  - opcode localparams OP_SOMA..OP_NOT;
  - FSM state encoding (2-bit);
  - function is_muldiv(op);
  - function is_illegal(op).
- Sub-module ula_rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid[1:0], enable (state==IDLE).
  - Outputs: grant[1:0], grant_id.
  - Holds Prio, updated on accept.
- ula_8bits is instantiated unchanged inside ula_ctrl_arb.

Test Plan:
1. Req0 A=50 B=30 Op=0000, Resp_Ready=1 -> Resp_Valid 2 clocks after accept, Resultado=80, Id=0, Maior=1 Menor=0 Igual=0, Erro=0.
2. Req1 A=20 B=20 Op=0010 -> Resultado=400 (0x0190) 4 clocks after accept, Igual=1. Then A=3 B=90 -> Resultado=270.
3. Req0 and Req1 held valid for 4 ops each -> grant order 0,1,0,1,…. Check Ready one-hot, Prio=0 after reset, Resp_Id matches grant.
4. Req0 A=23 B=0 Op=0100 -> Erro=1, Resultado=0, latency 1. Op=0101 A=7 B=3 -> Erro=1, Menor=0, Maior=1. Next legal op 23 mod 5 -> 3.
5. Resp_Ready held 0 for 6 cycles after Resp_Valid -> Resp_* stable, both Req*_Ready=0. Release -> IDLE, next accept no earlier than the following cycle.
6. rst_n pulsed low during EXEC of Op 0011 (100/5) -> all outputs 0 asynchronously, no response emitted. After release, new op 100/5 returns 20.
